mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive LSU wins allowed while fetch is pending; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port if_valid_i, input, 1 bit: fetch request pending.
REQ-005 SHALL have port if_addr_i, input, 32 bits: fetch word address.
REQ-006 SHALL have port if_flush_i, input, 1 bit: discard any in-flight fetch response (jmp/branch taken).
REQ-007 SHALL have port if_ready_o, output, 1 bit: fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid_o, output, 1 bit: fetch data valid, one-cycle pulse.
REQ-009 SHALL have port if_rdata_o, output, 32 bits: fetched instruction.
REQ-010 SHALL have ports lsu_valid_i, input, 1 bit, and lsu_we_i, input, 1 bit: LSU request pending, and request is a write.
REQ-011 SHALL have ports lsu_addr_i, input, 32 bits; lsu_wdata_i, input, 32 bits; and lsu_be_i, input, 4 bits: LSU address, write data and byte enables.
REQ-012 SHALL have ports lsu_ready_o, output, 1 bit; lsu_rvalid_o, output, 1 bit; and lsu_rdata_o, output, 32 bits: accept, response pulse and load data.
REQ-013 SHALL have ports mem_req_o, output, 1; mem_we_o, output, 1; mem_addr_o, output, 32; mem_wdata_o, output, 32; and mem_be_o, output, 4: memory request.
REQ-014 SHALL have ports mem_gnt_i, input, 1; mem_rvalid_i, input, 1; and mem_rdata_i, input, 32: memory grant, response and read data.

Function
REQ-015 SHALL implement FSM states IDLE, REQ (mem_req_o high, waiting for grant) and RESP (waiting for mem_rvalid_i), with at most one outstanding transaction.
REQ-016 In IDLE with any valid_i high, SHALL select one owner, assert that owner's ready_o combinationally for that cycle, register address, we, wdata and be onto the mem_* outputs, and move to REQ.
REQ-017 Selection SHALL be LSU-priority, except fetch wins when if_valid_i=1 and the starve counter equals STARVE_MAX.
REQ-018 Fetch requests SHALL drive mem_we_o=0 and mem_be_o=4'hF.
REQ-019 The 4-bit starve counter SHALL increment, saturating at STARVE_MAX, when LSU wins while if_valid_i=1; clear when fetch wins; otherwise hold.
REQ-020 In REQ, mem_req_o SHALL stay 1 and all mem_* fields SHALL stay stable until mem_gnt_i=1; on grant, next state SHALL be RESP and mem_req_o SHALL be 0 from the next cycle.
REQ-021 In RESP with mem_rvalid_i=1, SHALL pulse the owner's rvalid_o for exactly one cycle (the cycle after rvalid) and return to IDLE.
REQ-022 Reads SHALL register mem_rdata_i into the owner's rdata_o; LSU writes SHALL pulse lsu_rvalid_o as an acknowledge and load lsu_rdata_o with 0.
REQ-023 Minimum turnaround SHALL be: accept at N, mem_req_o at N+1, grant at N+1, rvalid at N+2, rvalid_o at N+3, next accept at N+3.
REQ-024 if_flush_i=1 while fetch owns REQ or RESP SHALL set a drop flag; the corresponding response SHALL complete on the memory side with if_rvalid_o suppressed; the flag SHALL clear on return to IDLE.
REQ-025 if_flush_i in the same cycle as mem_rvalid_i for a fetch SHALL suppress that pulse.
REQ-026 if_flush_i in IDLE SHALL have no effect.
REQ-027 mem_rvalid_i or mem_gnt_i outside RESP/REQ respectively SHALL be ignored.
REQ-028 ready_o SHALL never assert outside IDLE, and never both in one cycle.
REQ-029 if_rdata_o and lsu_rdata_o SHALL hold their values between pulses.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force state to IDLE, the starve counter and drop flag to 0, and all outputs to 0, abandoning any in-flight transaction; responses arriving after reset release SHALL be ignored.

Verification
REQ-031 Single fetch: if_valid_i=1, addr 0x100, grant immediate, rdata 0x00500093 -> if_ready_o at N, mem_addr_o=0x100 at N+1, if_rvalid_o with 0x00500093 at N+3.
REQ-032 Contention: both valid continuously, STARVE_MAX=4 -> grant order LSU,LSU,LSU,LSU,IF,LSU...; counter reads 0 after the IF win.
REQ-033 Grant stall: mem_gnt_i low for 5 cycles -> mem_req_o high with stable addr/we/wdata/be for 6 cycles, single transaction.
REQ-034 LSU write: we=1, addr 0x2000, wdata 0xDEADBEEF, be=4'b0011 -> mem_* match; lsu_rvalid_o pulses with lsu_rdata_o=0.
REQ-035 Flush: if_flush_i during fetch RESP, and separately coincident with mem_rvalid_i -> if_rvalid_o never pulses; next LSU request accepted in the following IDLE.
REQ-036 Reset mid-RESP: rst_n low then high, stale mem_rvalid_i=1 -> no rvalid_o pulse, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, LSU and memory-side signals of the
// shared memory port arbiter.
//   slave  - arbiter view: takes fetch/LSU requests and memory responses,
//            drives accepts, responses and the memory request.
//   master - environment view: requesters and the memory, mirror image.
interface mem_port_arbiter_if;
  // fetch side
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_ready_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  // LSU side
  logic        lsu_valid_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_be_i;
  logic        lsu_ready_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  // memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  if_valid_i, if_addr_i, if_flush_i,
    output if_ready_o, if_rvalid_o, if_rdata_o,
    input  lsu_valid_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
    output lsu_ready_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_valid_i, if_addr_i, if_flush_i,
    input  if_ready_o, if_rvalid_o, if_rdata_o,
    output lsu_valid_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
    input  lsu_ready_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// LSU with at most one outstanding transaction. LSU has priority; fetch is
// forced through after STARVE_MAX consecutive LSU wins while it waits.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave: fetch request/response, LSU
//            request/response, memory request/grant/response
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4  // 1..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic       owner_lsu;
  logic [3:0] starve_cnt;
  logic       drop;
  logic       fetch_win;
  logic       lsu_win;

  always_comb begin
    fetch_win = 1'b0;
    lsu_win   = 1'b0;
    if (state == ST_IDLE) begin
      fetch_win = bus.if_valid_i && (!bus.lsu_valid_i || starve_cnt == STARVE_LIM);
      lsu_win   = bus.lsu_valid_i && !fetch_win;
    end
  end

  assign bus.if_ready_o  = fetch_win;
  assign bus.lsu_ready_o = lsu_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      owner_lsu        <= 1'b0;
      starve_cnt       <= '0;
      drop             <= 1'b0;
      bus.mem_req_o    <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
      bus.mem_be_o     <= '0;
      bus.if_rvalid_o  <= 1'b0;
      bus.if_rdata_o   <= '0;
      bus.lsu_rvalid_o <= 1'b0;
      bus.lsu_rdata_o  <= '0;
    end else begin
      bus.if_rvalid_o  <= 1'b0;
      bus.lsu_rvalid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_win) begin
            owner_lsu       <= 1'b0;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= bus.if_addr_i;
            bus.mem_wdata_o <= '0;
            bus.mem_be_o    <= '1;
            starve_cnt      <= '0;
            state           <= ST_REQ;
          end else if (lsu_win) begin
            owner_lsu       <= 1'b1;
            bus.mem_req_o   <= 1'b1;
            bus.mem_we_o    <= bus.lsu_we_i;
            bus.mem_addr_o  <= bus.lsu_addr_i;
            bus.mem_wdata_o <= bus.lsu_wdata_i;
            bus.mem_be_o    <= bus.lsu_be_i;
            if (bus.if_valid_i && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
            state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!owner_lsu && bus.if_flush_i)
            drop <= 1'b1;
          if (bus.mem_gnt_i) begin
            bus.mem_req_o <= 1'b0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!owner_lsu && bus.if_flush_i)
            drop <= 1'b1;
          if (bus.mem_rvalid_i) begin
            // later assignment overrides the set above: flag clears on exit
            drop  <= 1'b0;
            state <= ST_IDLE;
            if (owner_lsu) begin
              bus.lsu_rvalid_o <= 1'b1;
              bus.lsu_rdata_o  <= bus.mem_we_o ? '0 : bus.mem_rdata_i;
            end else if (!(drop || bus.if_flush_i)) begin
              bus.if_rvalid_o <= 1'b1;
              bus.if_rdata_o  <= bus.mem_rdata_i;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus for mem_port_arbiter,
// checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: the single outstanding transaction and its progress
  int          m_phase;   // 0 free, 1 waiting for grant, 2 waiting for data
  bit          m_lsu;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          m_drop;
  bit          e_if_rv;
  bit          e_lsu_rv;
  logic [31:0] e_if_rd;
  logic [31:0] e_lsu_rd;
  int          if_pulses;
  int          req_cnt;
  int          win_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < 32'(p);
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_lsu    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    m_starve = 0;
    m_drop   = 1'b0;
    e_if_rv  = 1'b0;
    e_lsu_rv = 1'b0;
    e_if_rd  = '0;
    e_lsu_rd = '0;
  endtask

  task automatic clear_inputs();
    bus.if_valid_i   = 1'b0;
    bus.if_addr_i    = '0;
    bus.if_flush_i   = 1'b0;
    bus.lsu_valid_i  = 1'b0;
    bus.lsu_we_i     = 1'b0;
    bus.lsu_addr_i   = '0;
    bus.lsu_wdata_i  = '0;
    bus.lsu_be_i     = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // new inputs 1 time unit after the rising edge; callers may override fields
  task automatic drive(input int p_if, input int p_lsu, input int p_gnt,
                       input int p_rv, input int p_fl);
    @(posedge clk);
    #1;
    bus.if_valid_i   = pct(p_if);
    bus.if_addr_i    = $urandom;
    bus.if_flush_i   = pct(p_fl);
    bus.lsu_valid_i  = pct(p_lsu);
    bus.lsu_we_i     = pct(50);
    bus.lsu_addr_i   = $urandom;
    bus.lsu_wdata_i  = $urandom;
    bus.lsu_be_i     = 4'($urandom);
    bus.mem_gnt_i    = pct(p_gnt);
    bus.mem_rvalid_i = pct(p_rv);
    bus.mem_rdata_i  = $urandom;
  endtask

  // sample on the falling edge, compare, then advance the model one cycle
  task automatic step();
    bit fw;
    bit lw;
    #4;
    fw = (m_phase == 0) && bus.if_valid_i && (!bus.lsu_valid_i || m_starve == SM);
    lw = (m_phase == 0) && bus.lsu_valid_i && !fw;
    check_eq("if_ready", 32'(bus.if_ready_o), 32'(fw));
    check_eq("lsu_ready", 32'(bus.lsu_ready_o), 32'(lw));
    check_eq("mem_req", 32'(bus.mem_req_o), 32'(m_phase == 1));
    if (m_phase == 1) begin
      check_eq("mem_addr", bus.mem_addr_o, m_addr);
      check_eq("mem_we", 32'(bus.mem_we_o), 32'(m_we));
      check_eq("mem_be", 32'(bus.mem_be_o), 32'(m_be));
      if (m_lsu)
        check_eq("mem_wdata", bus.mem_wdata_o, m_wdata);
    end
    check_eq("if_rvalid", 32'(bus.if_rvalid_o), 32'(e_if_rv));
    check_eq("if_rdata", bus.if_rdata_o, e_if_rd);
    check_eq("lsu_rvalid", 32'(bus.lsu_rvalid_o), 32'(e_lsu_rv));
    check_eq("lsu_rdata", bus.lsu_rdata_o, e_lsu_rd);
    check_eq("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
    if (bus.if_ready_o) win_log.push_back(0);
    if (bus.lsu_ready_o) win_log.push_back(1);
    if (bus.if_rvalid_o) if_pulses++;
    if (bus.mem_req_o) req_cnt++;

    e_if_rv  = 1'b0;
    e_lsu_rv = 1'b0;
    case (m_phase)
      0: begin
        if (fw) begin
          m_lsu = 1'b0; m_we = 1'b0; m_addr = bus.if_addr_i; m_be = 4'hF;
          m_starve = 0;
          m_phase = 1;
        end else if (lw) begin
          m_lsu = 1'b1; m_we = bus.lsu_we_i; m_addr = bus.lsu_addr_i;
          m_wdata = bus.lsu_wdata_i; m_be = bus.lsu_be_i;
          if (bus.if_valid_i && m_starve < SM) m_starve++;
          m_phase = 1;
        end
      end
      1: begin
        if (!m_lsu && bus.if_flush_i) m_drop = 1'b1;
        if (bus.mem_gnt_i) m_phase = 2;
      end
      default: begin
        if (!m_lsu && bus.if_flush_i) m_drop = 1'b1;
        if (bus.mem_rvalid_i) begin
          if (m_lsu) begin
            e_lsu_rv = 1'b1;
            e_lsu_rd = m_we ? 32'h0 : bus.mem_rdata_i;
          end else if (!m_drop) begin
            e_if_rv = 1'b1;
            e_if_rd = bus.mem_rdata_i;
          end
          m_drop  = 1'b0;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 100, 100, 0);
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'h0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'h0);
    check_eq({tag, "_mem_we_be"}, 32'({bus.mem_we_o, bus.mem_be_o}), 32'h0);
    check_eq({tag, "_rvalids"}, 32'({bus.if_rvalid_o, bus.lsu_rvalid_o}), 32'h0);
    check_eq({tag, "_if_rdata"}, bus.if_rdata_o, 32'h0);
    check_eq({tag, "_lsu_rdata"}, bus.lsu_rdata_o, 32'h0);
  endtask

  // asynchronous reset asserted between edges, released 3 units after a rising edge
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic fetch_into_resp(input logic [31:0] addr);
    drive(0, 0, 0, 0, 0);
    bus.if_valid_i = 1'b1;
    bus.if_addr_i  = addr;
    step();
    drive(0, 0, 100, 0, 0);
    step();
  endtask

  initial begin
    int exp_order[6];
    int base;
    int p_if, p_lsu, p_gnt, p_rv, p_fl;
    exp_order = '{1, 1, 1, 1, 0, 1};
    if_pulses = 0;
    req_cnt   = 0;
    clear_inputs();
    model_reset();
    #2;
    check_all_zero("por");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle_cycles(2);

    // single fetch, immediate grant
    drive(0, 0, 100, 100, 0);
    bus.if_valid_i  = 1'b1;
    bus.if_addr_i   = 32'h100;
    bus.mem_rdata_i = 32'h00500093;
    step();
    check_eq("sf_ready_N", 32'(bus.if_ready_o), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 100, 100, 0);
      bus.mem_rdata_i = 32'h00500093;
      step();
      if (i == 1) check_eq("sf_addr_N1", bus.mem_addr_o, 32'h100);
      if (i == 3) begin
        check_eq("sf_rvalid_N3", 32'(bus.if_rvalid_o), 32'h1);
        check_eq("sf_rdata_N3", bus.if_rdata_o, 32'h00500093);
      end
    end

    // contention: both requesters continuously valid
    idle_cycles(2);
    win_log.delete();
    for (int i = 0; i < 24; i++) begin
      drive(100, 100, 100, 100, 0);
      step();
    end
    check_eq("ct_nwins", 32'(win_log.size() >= 6), 32'h1);
    for (int i = 0; i < 6; i++)
      if (i < win_log.size())
        check_eq($sformatf("ct_order%0d", i), 32'(win_log[i]), 32'(exp_order[i]));

    // grant stall of 5 cycles
    idle_cycles(4);
    drive(0, 0, 0, 0, 0);
    bus.lsu_valid_i = 1'b1;
    step();
    req_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 100, 0, 0);
    step();
    drive(0, 0, 0, 100, 0);
    step();
    check_eq("gs_req_cycles", 32'(req_cnt), 32'd6);

    // LSU write
    idle_cycles(2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 100, 100, 0);
      if (i == 0) begin
        bus.lsu_valid_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_addr_i = 32'h2000;
        bus.lsu_wdata_i = 32'hDEADBEEF; bus.lsu_be_i = 4'b0011;
      end
      step();
      if (i == 1) begin
        check_eq("wr_addr", bus.mem_addr_o, 32'h2000);
        check_eq("wr_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
        check_eq("wr_we_be", 32'({bus.mem_we_o, bus.mem_be_o}), 32'h13);
      end
      if (i == 3) begin
        check_eq("wr_ack", 32'(bus.lsu_rvalid_o), 32'h1);
        check_eq("wr_rdata", bus.lsu_rdata_o, 32'h0);
      end
    end

    // flush while waiting for data, then flush coincident with data
    idle_cycles(2);
    base = if_pulses;
    fetch_into_resp(32'h300);
    drive(0, 0, 0, 0, 0);
    bus.if_flush_i = 1'b1;
    step();
    drive(0, 0, 0, 100, 0);
    step();
    drive(0, 100, 100, 0, 0);
    step();
    check_eq("fl1_lsu_acc", 32'(bus.lsu_ready_o), 32'h1);
    idle_cycles(4);
    fetch_into_resp(32'h400);
    drive(0, 0, 0, 100, 0);
    bus.if_flush_i = 1'b1;
    step();
    drive(0, 100, 100, 0, 0);
    step();
    check_eq("fl2_no_pulse", 32'(bus.if_rvalid_o), 32'h0);
    check_eq("fl2_lsu_acc", 32'(bus.lsu_ready_o), 32'h1);
    idle_cycles(4);
    check_eq("fl_pulses", 32'(if_pulses - base), 32'h0);

    // reset while waiting for data, stale response afterwards
    fetch_into_resp(32'h500);
    do_reset("rst_mid");
    base = if_pulses;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 100, 0);
      step();
    end
    check_all_zero("rst_after");
    check_eq("rst_pulses", 32'(if_pulses - base), 32'h0);
    drive(100, 0, 100, 100, 0);
    step();
    check_eq("rst_idle_acc", 32'(bus.if_ready_o), 32'h1);

    // random traffic with a changing mix
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        p_if  = int'($urandom_range(100));
        p_lsu = int'($urandom_range(100));
        p_gnt = int'($urandom_range(90)) + 10;
        p_rv  = int'($urandom_range(90)) + 10;
        p_fl  = int'($urandom_range(30));
      end
      if (k == 1500) begin
        step_after_reset_guard: begin
          do_reset("rst_rand");
        end
      end
      drive(p_if, p_lsu, p_gnt, p_rv, p_fl);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
